// File: rtl/debounce_pkg.sv
// Shared types for the key debouncer bank.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package debounce_pkg;

    // Per-channel debounce FSM states; encoding is fixed so state dumps read consistently.
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        CONF_PRESS = 2'd1,
        PRESSED    = 2'd2,
        CONF_REL   = 2'd3
    } deb_state_t;

endpackage

// File: rtl/debounce_channel.sv
// One debounced key: 2-flop synchroniser, stable-time filter, hold timer, event pulses.
// Latency: level/press/release 1+STABLE_CYCLES edges after the raw change; long press LONG_CYCLES after press.
// Backpressure: none; events are single-cycle pulses that the consumer must sample.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = 15,
    parameter int LONG_CYCLES   = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic key_in,
    output logic key_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    localparam int DEB_W  = $clog2(STABLE_CYCLES);
    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

    localparam logic [DEB_W-1:0]  DEB_ONE   = DEB_W'(1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(STABLE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

    logic              s1_q;
    logic              s2_q;
    deb_state_t        state_q;
    logic [DEB_W-1:0]  deb_q;
    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] hold_d;
    logic              long_hit;
    logic              level_q;
    logic              press_q;
    logic              release_q;
    logic              long_q;

    // Synchroniser runs regardless of en so a re-enable sees a settled sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= key_in;
            s2_q <= s1_q;
        end
    end

    // Saturating hold timer; the long event fires on the step that reaches LONG_CYCLES.
    always_comb begin
        hold_d   = hold_q;
        long_hit = (hold_q == HOLD_LAST);
        if (hold_q != HOLD_MAX) begin
            hold_d = hold_q + HOLD_ONE;
        end
    end

    // Debounce FSM with registered level and one-cycle event pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            deb_q     <= '0;
            hold_q    <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else if (!en) begin
            // Disable drops the key silently: no release event is reported.
            state_q   <= IDLE;
            deb_q     <= '0;
            hold_q    <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (s2_q) begin
                        state_q <= CONF_PRESS;
                        deb_q   <= DEB_ONE;
                    end
                end
                CONF_PRESS: begin
                    if (!s2_q) begin
                        state_q <= IDLE;
                        deb_q   <= '0;
                    end else if (deb_q == DEB_LAST) begin
                        state_q <= PRESSED;
                        deb_q   <= '0;
                        hold_q  <= '0;
                        level_q <= 1'b1;
                        press_q <= 1'b1;
                    end else begin
                        deb_q <= deb_q + DEB_ONE;
                    end
                end
                PRESSED: begin
                    hold_q <= hold_d;
                    long_q <= long_hit;
                    if (!s2_q) begin
                        state_q <= CONF_REL;
                        deb_q   <= DEB_ONE;
                    end
                end
                CONF_REL: begin
                    if (!s2_q && (deb_q == DEB_LAST)) begin
                        // Accepted release beats a long press landing on the same edge.
                        state_q   <= IDLE;
                        deb_q     <= '0;
                        hold_q    <= '0;
                        level_q   <= 1'b0;
                        release_q <= 1'b1;
                    end else begin
                        // Release bounces keep the hold timer running.
                        hold_q <= hold_d;
                        long_q <= long_hit;
                        if (s2_q) begin
                            state_q <= PRESSED;
                            deb_q   <= '0;
                        end else begin
                            deb_q <= deb_q + DEB_ONE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    deb_q   <= '0;
                    hold_q  <= '0;
                    level_q <= 1'b0;
                end
            endcase
        end
    end

    assign key_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_pulse    = long_q;

endmodule

// File: rtl/debounce_bank.sv
// Bank of independent key debouncers with optional active-low input polarity.
// Latency: 1+STABLE_CYCLES edges for level/press/release; long press LONG_CYCLES edges after press.
// Backpressure: none; per-channel event pulses are one cycle wide and may coincide.
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int CHANNELS      = 4,
    parameter int STABLE_CYCLES = 15,
    parameter int LONG_CYCLES   = 255,
    parameter bit ACTIVE_LOW    = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [CHANNELS-1:0] key_in,
    output logic [CHANNELS-1:0] key_level,
    output logic [CHANNELS-1:0] press_pulse,
    output logic [CHANNELS-1:0] release_pulse,
    output logic [CHANNELS-1:0] long_pulse
);

    // Normalise polarity ahead of the synchronisers so every channel sees 1 = pressed.
    logic [CHANNELS-1:0] key_raw;
    assign key_raw = ACTIVE_LOW ? ~key_in : key_in;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        debounce_channel #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .LONG_CYCLES   (LONG_CYCLES)
        ) u_ch (
            .clk           (clk),
            .rst           (rst),
            .en            (en),
            .key_in        (key_raw[g]),
            .key_level     (key_level[g]),
            .press_pulse   (press_pulse[g]),
            .release_pulse (release_pulse[g]),
            .long_pulse    (long_pulse[g])
        );
    end

endmodule

// File: doc/debounce_bank.md
# debounce_bank

Multi-channel key debouncer with press, release and long-press event detection. Each of CHANNELS raw inputs is synchronised, glitch-filtered against a programmable stable-time threshold and tracked for hold duration. It sits between board push-buttons/switches and control FSMs, which consume its single-cycle event pulses and its clean level outputs. It supersedes the single-counter debounce path with per-channel state, polarity selection and long-press reporting.

## Interface
- CHANNELS, 4: number of independent input channels (≥1).
- STABLE_CYCLES, 15: consecutive synchronised samples required to accept a level change (≥2).
- LONG_CYCLES, 255: cycles after press acceptance at which a long press is reported (> STABLE_CYCLES).
- ACTIVE_LOW, 0: 1 = raw inputs are active-low and are inverted before the synchroniser.
- Localparams: DEB_W = $clog2(STABLE_CYCLES), HOLD_W = $clog2(LONG_CYCLES+1).

- clk  in  1  system clock; all logic on posedge.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  1 = debouncing active; 0 = synchronous clear of all channel state.
- key_in  in  CHANNELS  raw asynchronous key inputs.
- key_level  out  CHANNELS  debounced level, 1 = pressed.
- press_pulse  out  CHANNELS  one-cycle pulse on accepted press.
- release_pulse  out  CHANNELS  one-cycle pulse on accepted release.
- long_pulse  out  CHANNELS  one-cycle pulse, once per press, at LONG_CYCLES hold.

## Operation
- Input path per channel: optional inversion (ACTIVE_LOW), then 2-flop synchroniser s1→s2; the FSM samples s2.
- Per-channel FSM, states IDLE, CONF_PRESS, PRESSED, CONF_REL; deb_cnt (DEB_W bits); hold_cnt (HOLD_W bits).
- IDLE: s2=1 → CONF_PRESS, deb_cnt←1. s2=0 → stay.
- CONF_PRESS: s2=0 → IDLE, deb_cnt←0 (glitch rejected, no pulse). s2=1 and deb_cnt==STABLE_CYCLES-1 → PRESSED, key_level←1, press_pulse←1, hold_cnt←0. Otherwise deb_cnt+1.
- PRESSED: hold_cnt increments, saturating at LONG_CYCLES; long_pulse←1 on the edge where hold_cnt becomes LONG_CYCLES. s2=0 → CONF_REL, deb_cnt←1.
- CONF_REL: hold_cnt keeps counting/saturating as in PRESSED (long_pulse may fire here). s2=1 → PRESSED, deb_cnt←0, hold_cnt not cleared. s2=0 and deb_cnt==STABLE_CYCLES-1 → IDLE, key_level←0, release_pulse←1, hold_cnt←0. Otherwise deb_cnt+1.
- Channels fully independent; any combination of pulses may assert in the same cycle.
- en=0: at each edge all channels → IDLE, counters 0, key_level 0, pulses 0; synchroniser keeps running. No release_pulse is generated by the disable.
- All outputs registered; each pulse is high for exactly one cycle.

## Timing
- Reset: all FSMs IDLE, s1/s2/deb_cnt/hold_cnt 0, key_level/press_pulse/release_pulse/long_pulse all 0. Reset mid-confirm discards the partial count.
- Press latency: with key_in asserted before edge 0 and held, key_level and press_pulse are high after edge 1+STABLE_CYCLES (edge 16 at defaults).
- Release latency: identical, 1+STABLE_CYCLES edges after de-assertion.
- Long press: long_pulse high exactly LONG_CYCLES edges after the press_pulse edge, provided the release is not accepted first; never repeats within a press.
- Release accepted on the same edge hold_cnt would reach LONG_CYCLES: release wins, no long_pulse.
- Minimum accepted pulse width: STABLE_CYCLES consecutive s2 samples; shorter excursions produce no event.

## Structure
- Package debounce_pkg: 2-bit state enum (IDLE=0, CONF_PRESS=1, PRESSED=2, CONF_REL=3).
- Sub-module debounce_channel: synchroniser, FSM and both counters for one channel; debounce_bank instantiates it CHANNELS times via generate and applies ACTIVE_LOW inversion.

## Test plan
Bench: CHANNELS=4, STABLE_CYCLES=4, LONG_CYCLES=12, ACTIVE_LOW=0.
- Clean press ch0 at edge 0, held 40 cycles → press_pulse[0] after edge 5, long_pulse[0] after edge 17; release at edge 40 → release_pulse[0] after edge 45, key_level[0] 0.
- Glitch ch1 high for 3 cycles → no pulses, key_level[1] stays 0; high for 4 cycles → press accepted.
- Bounce on release ch2 (low 2, high 1, low steady) → single release_pulse[2], 5 edges after the final fall; hold_cnt not reset by the bounce.
- All 4 channels pressed on the same edge → four simultaneous press_pulse bits; ch3 released at hold 12 with release accepted first → no long_pulse[3].
- Async rst asserted mid-CONF_PRESS, and separately en=0 while PRESSED → all outputs 0 immediately (rst) or next edge (en); re-press requires a full 1+STABLE_CYCLES latency.
- ACTIVE_LOW=1 instance with idle inputs high → no events; driving input low for 10 cycles → press_pulse after edge 5.
